exec_sequencer: RTL

- Multi-cycle execution controller for the picoMIPS datapath.
- Takes decoded instruction-class flags from the decoder and sequences the synchronous multiplier, STIN input handshake and LOUT output handshake.
- Gates the PC advance and register-file write enable so each instruction retires exactly once.
- Sits between the decoder and the pc / reg_file / sync_smult / output register.

---
 rtl/exec_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle execution controller for picoMIPS: sequences multiply, STIN and LOUT, gates PC/regfile.
// Optional I/O wait timeout enabled by defining IO_TIMEOUT_EN.
module exec_sequencer #(
   parameter int unsigned MultLatency   = 2,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       run,
   input  logic       mult,
   input  logic       read_in,
   input  logic       write_out,
   input  logic       reg_write,
   input  logic       in_valid,
   input  logic       out_ready,
   output logic       pc_en,
   output logic       reg_we,
   output logic [1:0] wdata_sel,
   output logic       mult_start,
   output logic       in_ack,
   output logic       out_load,
   output logic       out_valid,
   output logic       busy,
   output logic       timeout_err
);

   localparam int unsigned CntMax = (TimeoutCycles > 15) ? TimeoutCycles : 15;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   typedef enum logic [1:0] {
      EXEC      = 2'd0,
      MULT_WAIT = 2'd1,
      IN_WAIT   = 2'd2,
      OUT_WAIT  = 2'd3
   } state_t;

   state_t          r_state, w_state_next;
   logic [CntW-1:0] r_cnt, w_cnt_next;
   logic            r_out_valid, w_out_valid_next;
`ifdef IO_TIMEOUT_EN
   logic            r_timeout_err;
   logic            w_timeout;
`endif

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state     <= EXEC;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_out_valid <= w_out_valid_next;
      end
   end

   // Outputs are forced low while reset is held, even though EXEC would otherwise retire.
   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_out_valid_next = r_out_valid;
      pc_en            = 1'b0;
      reg_we           = 1'b0;
      wdata_sel        = 2'b00;
      mult_start       = 1'b0;
      in_ack           = 1'b0;
      out_load         = 1'b0;
`ifdef IO_TIMEOUT_EN
      w_timeout        = 1'b0;
`endif
      if (n_reset) begin
         case (r_state)
            EXEC: begin
               if (run) begin
                  if (mult) begin
                     mult_start   = 1'b1;
                     w_cnt_next   = CntW'(MultLatency);
                     w_state_next = MULT_WAIT;
                  end else if (read_in) begin
                     if (in_valid) begin
                        reg_we    = 1'b1;
                        wdata_sel = 2'b01;
                        in_ack    = 1'b1;
                        pc_en     = 1'b1;
                     end else begin
                        w_cnt_next   = CntOne;
                        w_state_next = IN_WAIT;
                     end
                  end else if (write_out) begin
                     out_load         = 1'b1;
                     w_out_valid_next = 1'b1;
                     w_cnt_next       = CntOne;
                     w_state_next     = OUT_WAIT;
                  end else begin
                     pc_en  = 1'b1;
                     reg_we = reg_write;
                  end
               end
            end
            MULT_WAIT: begin
               w_cnt_next = r_cnt - CntOne;
               if (r_cnt == CntOne) begin
                  reg_we       = 1'b1;
                  wdata_sel    = 2'b10;
                  pc_en        = 1'b1;
                  w_state_next = EXEC;
               end
            end
            IN_WAIT: begin
               if (in_valid) begin
                  reg_we       = 1'b1;
                  wdata_sel    = 2'b01;
                  in_ack       = 1'b1;
                  pc_en        = 1'b1;
                  w_state_next = EXEC;
`ifdef IO_TIMEOUT_EN
               end else if (r_cnt == CntW'(TimeoutCycles)) begin
                  w_timeout    = 1'b1;
                  pc_en        = 1'b1;
                  w_state_next = EXEC;
               end else begin
                  w_cnt_next = r_cnt + CntOne;
`endif
               end
            end
            OUT_WAIT: begin
               if (out_ready) begin
                  pc_en            = 1'b1;
                  w_out_valid_next = 1'b0;
                  w_state_next     = EXEC;
`ifdef IO_TIMEOUT_EN
               end else if (r_cnt == CntW'(TimeoutCycles)) begin
                  w_timeout        = 1'b1;
                  pc_en            = 1'b1;
                  w_out_valid_next = 1'b0;
                  w_state_next     = EXEC;
               end else begin
                  w_cnt_next = r_cnt + CntOne;
`endif
               end
            end
            default: w_state_next = EXEC;
         endcase
      end
   end

`ifdef IO_TIMEOUT_EN
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_timeout_err <= 1'b0;
      end else if (w_timeout) begin
         r_timeout_err <= 1'b1;
      end
   end
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

   assign out_valid = r_out_valid;
   assign busy      = (r_state != EXEC);

endmodule
